// File: rtl/sr_pkg.sv
// Shared definitions for the status-register stack: image bit positions,
// the per-level {ie,mode} record and the per-level update selector.
package sr_pkg;

    localparam int SR_W        = 32;
    localparam int SR_OVF_BIT  = 31;
    localparam int SR_UNF_BIT  = 30;
    localparam int SR_NEST_LSB = 20;
    localparam int SR_NEST_W   = 3;

    // ie sits above mode so a packed level drops straight into bits [2L+1:2L].
    typedef struct packed {
        logic ie;
        logic mode;
    } sr_level_t;

    typedef enum logic [1:0] {
        LVL_HOLD  = 2'd0,
        LVL_PUSH  = 2'd1,
        LVL_POP   = 2'd2,
        LVL_WRITE = 2'd3
    } level_op_e;

endpackage

// File: rtl/sr_stack_if.sv
// Request/response bundle between the status-register stack and its user
// (exception/RFE strobes, mtc0/mfc0 image path and decoded level-0 outputs).
interface sr_stack_if;
    import sr_pkg::*;

    logic                 exception;
    logic                 rfe;
    logic                 sr_we;
    logic [SR_W-1:0]      sr_wdata;
    logic [SR_W-1:0]      sr_rdata;
    logic                 IE_c;
    logic                 s_u_c;
    logic [SR_NEST_W-1:0] nest_cnt;
    logic                 ovf;
    logic                 unf;

    modport master (
        output exception, rfe, sr_we, sr_wdata,
        input  sr_rdata, IE_c, s_u_c, nest_cnt, ovf, unf
    );

    modport slave (
        input  exception, rfe, sr_we, sr_wdata,
        output sr_rdata, IE_c, s_u_c, nest_cnt, ovf, unf
    );

endinterface

// File: rtl/sr_stack_level.sv
// One {ie,mode} stack level: selects between hold, value from the level
// above (push), value from the level below (pop) or a software write.
module sr_stack_level
    import sr_pkg::*;
#(
    parameter sr_level_t RST_VAL = 2'b11
) (
    input  logic      clk,
    input  logic      rst,
    input  level_op_e op_i,
    input  sr_level_t push_val_i,
    input  sr_level_t pop_val_i,
    input  sr_level_t wr_val_i,
    output sr_level_t lvl_o
);

    sr_level_t lvl_q;
    sr_level_t lvl_d;

    // Next-value mux driven by the top-level priority decode.
    always_comb begin
        lvl_d = lvl_q;
        case (op_i)
            LVL_PUSH:  lvl_d = push_val_i;
            LVL_POP:   lvl_d = pop_val_i;
            LVL_WRITE: lvl_d = wr_val_i;
            default:   lvl_d = lvl_q;
        endcase
    end

    // Level register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) lvl_q <= RST_VAL;
        else      lvl_q <= lvl_d;
    end

    assign lvl_o = lvl_q;

endmodule

// File: rtl/sr_stack.sv
// Status register holding DEPTH+1 {IE,mode} levels. Level 0 drives the live
// interrupt-enable and supervisor outputs; exceptions push, RFE pops and
// software reads/writes a packed 32-bit image. Also tracks nesting depth
// and sticky overflow/underflow flags (write-0-to-clear).
module sr_stack
    import sr_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter logic RST_IE   = 1'b1,
    parameter logic RST_MODE = 1'b1,
    parameter logic EXC_IE   = 1'b0,
    parameter logic EXC_MODE = 1'b0
) (
    input logic       clk,
    input logic       rst,
    sr_stack_if.slave bus
);

    localparam sr_level_t                RST_LVL = '{ie: RST_IE, mode: RST_MODE};
    localparam sr_level_t                EXC_LVL = '{ie: EXC_IE, mode: EXC_MODE};
    localparam logic [SR_NEST_W-1:0]     DEPTH_C = SR_NEST_W'(DEPTH);

    level_op_e            op;
    sr_level_t            lvl [DEPTH+1];
    logic [SR_NEST_W-1:0] nest_q, nest_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [SR_NEST_W-1:0] wr_nest;
    logic                 unused_wdata;

    // Request priority: exception beats rfe beats software write.
    always_comb begin
        op = LVL_HOLD;
        if (bus.exception)  op = LVL_PUSH;
        else if (bus.rfe)   op = LVL_POP;
        else if (bus.sr_we) op = LVL_WRITE;
    end

    for (genvar i = 0; i <= DEPTH; i++) begin : g_lvl
        sr_level_t push_val;
        sr_level_t pop_val;

        if (i == 0) begin : g_top
            assign push_val = EXC_LVL;
        end else begin : g_mid
            assign push_val = lvl[i-1];
        end

        if (i == DEPTH) begin : g_bot
            assign pop_val = RST_LVL;
        end else begin : g_abv
            assign pop_val = lvl[i+1];
        end

        sr_stack_level #(
            .RST_VAL (RST_LVL)
        ) u_level (
            .clk        (clk),
            .rst        (rst),
            .op_i       (op),
            .push_val_i (push_val),
            .pop_val_i  (pop_val),
            .wr_val_i   (sr_level_t'(bus.sr_wdata[2*i +: 2])),
            .lvl_o      (lvl[i])
        );
    end

    // Software-written depth saturates at the number of saved levels.
    assign wr_nest = (bus.sr_wdata[SR_NEST_LSB +: SR_NEST_W] > DEPTH_C)
                   ? DEPTH_C : bus.sr_wdata[SR_NEST_LSB +: SR_NEST_W];

    // Nesting counter and sticky flags next-state.
    always_comb begin
        nest_d = nest_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        case (op)
            LVL_PUSH: begin
                if (nest_q == DEPTH_C) ovf_d  = 1'b1;
                else                   nest_d = nest_q + 1'b1;
            end
            LVL_POP: begin
                if (nest_q == '0) unf_d  = 1'b1;
                else              nest_d = nest_q - 1'b1;
            end
            LVL_WRITE: begin
                nest_d = wr_nest;
                ovf_d  = ovf_q & bus.sr_wdata[SR_OVF_BIT];
                unf_d  = unf_q & bus.sr_wdata[SR_UNF_BIT];
            end
            default: ;
        endcase
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nest_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            nest_q <= nest_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Packed read image; unimplemented bits read as zero.
    always_comb begin
        bus.sr_rdata = '0;
        for (int l = 0; l <= DEPTH; l++) bus.sr_rdata[2*l +: 2] = lvl[l];
        bus.sr_rdata[SR_NEST_LSB +: SR_NEST_W] = nest_q;
        bus.sr_rdata[SR_UNF_BIT]               = unf_q;
        bus.sr_rdata[SR_OVF_BIT]               = ovf_q;
    end

    assign bus.IE_c     = lvl[0].ie;
    assign bus.s_u_c    = lvl[0].mode;
    assign bus.nest_cnt = nest_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

    // Image bits with no backing register are deliberately ignored on write.
    assign unused_wdata = ^bus.sr_wdata;

endmodule

// File: tb/tb_sr_stack.sv
// Directed bench for sr_stack at DEPTH=2 with default reset/exception values.
module tb_sr_stack;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    sr_stack_if bus ();

    sr_stack #(
        .DEPTH    (2),
        .RST_IE   (1'b1),
        .RST_MODE (1'b1),
        .EXC_IE   (1'b0),
        .EXC_MODE (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        else             n_pass++;
    endtask

    // Apply one cycle of requests, then release them just after the edge.
    task automatic cyc(input logic r, input logic exc, input logic rf,
                       input logic we, input logic [31:0] wd);
        rst           = r;
        bus.exception = exc;
        bus.rfe       = rf;
        bus.sr_we     = we;
        bus.sr_wdata  = wd;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.exception = 1'b0;
        bus.rfe       = 1'b0;
        bus.sr_we     = 1'b0;
        bus.sr_wdata  = '0;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst           = 1'b0;
        bus.exception = 1'b0;
        bus.rfe       = 1'b0;
        bus.sr_we     = 1'b0;
        bus.sr_wdata  = '0;
        #2;

        // Reset state
        do_reset();
        chk("rst_ie",    32'(bus.IE_c),     32'd1);
        chk("rst_su",    32'(bus.s_u_c),    32'd1);
        chk("rst_nest",  32'(bus.nest_cnt), 32'd0);
        chk("rst_image", bus.sr_rdata,      32'h0000_003F);

        // Push twice, pop twice
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("push1",     bus.sr_rdata,      32'h0010_003C);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("push2_ie",  32'(bus.IE_c),     32'd0);
        chk("push2_su",  32'(bus.s_u_c),    32'd0);
        chk("push2",     bus.sr_rdata,      32'h0020_0030);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("pop1",      bus.sr_rdata,      32'h0010_003C);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("pop2",      bus.sr_rdata,      32'h0000_003F);
        chk("pop2_nest", 32'(bus.nest_cnt), 32'd0);

        // Overflow on third push, then clear with a zero write
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("ovf_flag",  32'(bus.ovf),      32'd1);
        chk("ovf_image", bus.sr_rdata,      32'h8020_0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("ovf_clr",   bus.sr_rdata,      32'h0000_0000);

        // Underflow: level0=10, others 00, pop at depth 0
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
        chk("sw_wr",     bus.sr_rdata,      32'h0000_0002);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("unf_flag",  32'(bus.unf),      32'd1);
        chk("unf_image", bus.sr_rdata,      32'h4000_0030);

        // Writing 1 to sticky bits keeps unf and does not set ovf
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hC000_0000);
        chk("w0c_keep",  bus.sr_rdata,      32'h4000_0000);

        // Depth saturation and bits above the deepest level ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0070_00FF);
        chk("wr_sat",    bus.sr_rdata,      32'h0020_003F);

        // exception+rfe: push only
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("exc_rfe",   bus.sr_rdata,      32'h0010_003C);
        // exception+sr_we: push only, write lost
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0003);
        chk("exc_we",    bus.sr_rdata,      32'h0020_0030);

        // rfe+sr_we: pop wins (underflow from reset state)
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("rfe_we",    bus.sr_rdata,      32'h4000_003F);

        // Reset while exception is asserted at depth 1
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_rst",   32'(bus.nest_cnt), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mid_rst",   bus.sr_rdata,      32'h0000_003F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
